dead_time_gen: RTL

- Output stage directly downstream of the PWM generator.
- Takes the single-ended `pwm_out` and produces a complementary high-side/low-side gate-drive pair.
- Inserts a separately configurable dead time on each transition, so the two outputs are never high together.
- Dead-time values and enable come from the register file; all logic runs in the system clock domain.

---
 rtl/dead_time_gen.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/dead_time_gen.sv
// Complementary high/low gate-drive pair with per-edge dead time.
// Optional DEAD_TIME_FAULT_EN adds a latched fault shutdown.
module dead_time_gen #(
    parameter int DT_W          = 8,
    parameter bit LO_ACTIVE_LOW = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            pwm_in,
    input  logic [DT_W-1:0] dead_rise,
    input  logic [DT_W-1:0] dead_fall,
    output logic            pwm_hi,
    output logic            pwm_lo,
    output logic            dt_active
`ifdef DEAD_TIME_FAULT_EN
    ,
    input  logic            fault_in,
    output logic            fault_flag
`endif
);

    typedef enum logic [2:0] {
        OFF     = 3'd0,
        LO_ON   = 3'd1,
        DT_RISE = 3'd2,
        HI_ON   = 3'd3,
        DT_FALL = 3'd4
`ifdef DEAD_TIME_FAULT_EN
        ,
        FAULT   = 3'd5
`endif
    } state_t;

    localparam logic [DT_W-1:0] ONE  = {{(DT_W-1){1'b0}}, 1'b1};
    localparam logic [DT_W-1:0] ZERO = '0;

    state_t          state, state_d;
    logic [DT_W-1:0] cnt, cnt_d;
    logic            hi_d, lo_d, dt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= OFF;
            cnt       <= ZERO;
            pwm_hi    <= 1'b0;
            pwm_lo    <= LO_ACTIVE_LOW;
            dt_active <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            pwm_hi    <= hi_d;
            pwm_lo    <= lo_d ^ LO_ACTIVE_LOW;
            dt_active <= dt_d;
        end
    end

`ifdef DEAD_TIME_FAULT_EN
    always_ff @(posedge clk) begin
        if (rst)
            fault_flag <= 1'b0;
        else
            fault_flag <= (state_d == FAULT);
    end
`endif

    // Dead-time values are only sampled on entry into a DT state.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
`ifdef DEAD_TIME_FAULT_EN
        if (fault_in) begin
            state_d = FAULT;
            cnt_d   = ZERO;
        end else
`endif
        if (!en) begin
            state_d = OFF;
            cnt_d   = ZERO;
        end else begin
            unique case (state)
                OFF: begin
                    state_d = pwm_in ? HI_ON : LO_ON;
                end
                LO_ON: begin
                    if (pwm_in) begin
                        if (dead_rise == ZERO) begin
                            state_d = HI_ON;
                        end else begin
                            state_d = DT_RISE;
                            cnt_d   = dead_rise - ONE;
                        end
                    end
                end
                DT_RISE: begin
                    if (!pwm_in)
                        state_d = LO_ON;
                    else if (cnt == ZERO)
                        state_d = HI_ON;
                    else
                        cnt_d = cnt - ONE;
                end
                HI_ON: begin
                    if (!pwm_in) begin
                        if (dead_fall == ZERO) begin
                            state_d = LO_ON;
                        end else begin
                            state_d = DT_FALL;
                            cnt_d   = dead_fall - ONE;
                        end
                    end
                end
                DT_FALL: begin
                    if (pwm_in)
                        state_d = HI_ON;
                    else if (cnt == ZERO)
                        state_d = LO_ON;
                    else
                        cnt_d = cnt - ONE;
                end
`ifdef DEAD_TIME_FAULT_EN
                FAULT: begin
                    state_d = FAULT;
                end
`endif
                default: begin
                    state_d = OFF;
                    cnt_d   = ZERO;
                end
            endcase
        end
    end

    always_comb begin
        hi_d = (state_d == HI_ON);
        lo_d = (state_d == LO_ON);
        dt_d = (state_d == DT_RISE) || (state_d == DT_FALL);
    end

endmodule
